// File: rtl/class_tree_pkg.sv
// Shared types and constants for the class-tree scheduler.
//   state_t    : scheduler FSM encoding
//   DEF_N_REQ  : default requester count
//   DEF_FEAT_W : default classifier feature width
//   ID_W       : requester index width at the default requester count
//   LAT_W      : settle-latency counter width (covers CLS_LAT up to 15)
package class_tree_pkg;
  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

  localparam int DEF_N_REQ  = 4;
  localparam int DEF_FEAT_W = 51;
  localparam int ID_W       = $clog2(DEF_N_REQ);
  localparam int LAT_W      = 4;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req : request vector
//   ptr : highest-priority index; the search runs upward from here with wrap
//   gnt : one-hot grant (all-zero when nothing requests)
//   idx : encoded index of the grant (0 when nothing requests)
module rr_arbiter
  import class_tree_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    int  j;
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/class_tree_sched.sv
// Shares one combinational class-tree classifier between N_REQ requesters.
// A round-robin winner's feature vector is registered onto cls_feat, the tree
// is given CLS_LAT cycles to settle, and the sampled class bit is returned to
// the winner over a valid/ready response channel.
//   clk, rst_n            : clock, async active-low reset
//   req_valid/req_feat    : per-requester request and packed feature vectors
//   req_ready             : one-hot accept (only in IDLE)
//   cls_feat / cls_class  : classifier input (registered) / output (sampled)
//   rsp_valid/ready/id/class : response channel
//   busy                  : FSM not in IDLE
//   pos_count             : saturating count of accepted class-1 responses
module class_tree_sched
  import class_tree_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int FEAT_W  = DEF_FEAT_W,
  parameter int CLS_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*FEAT_W-1:0]   req_feat,
  output logic [N_REQ-1:0]          req_ready,
  output logic [FEAT_W-1:0]         cls_feat,
  input  logic                      cls_class,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(N_REQ)-1:0]  rsp_id,
  output logic                      rsp_class,
  output logic                      busy,
  output logic [CNT_W-1:0]          pos_count
);

  localparam int RID_W = $clog2(N_REQ);

  state_t                         state, state_nxt;
  logic [RID_W-1:0]               ptr, gidx;
  logic [N_REQ-1:0]               gnt;
  logic [LAT_W-1:0]               cnt;
  logic [N_REQ-1:0][FEAT_W-1:0]   feat_arr;
  logic                           accept, lat_done;

  assign feat_arr = req_feat;

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(RID_W)) u_arb (
    .req (req_valid),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gidx)
  );

  // Grant is only offered in IDLE; gated by rst_n so it also reads zero while
  // reset is held, regardless of what the requesters drive.
  assign req_ready = (state == IDLE && rst_n) ? gnt : '0;
  assign accept    = |(req_valid & req_ready);
  assign lat_done  = (state == EVAL) && (cnt == '0);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = EVAL;
      EVAL:    if (lat_done)  state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cls_feat  <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_class <= 1'b0;
      pos_count <= '0;
      ptr       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          cls_feat <= feat_arr[gidx];
          rsp_id   <= gidx;
          cnt      <= LAT_W'(CLS_LAT - 1);
        end
        EVAL: begin
          if (lat_done) begin
            rsp_class <= cls_class;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          // Pointer moves only on completion, so the served requester drops
          // to lowest priority for the next grant.
          if (rsp_id == RID_W'(N_REQ - 1)) ptr <= '0;
          else                              ptr <= rsp_id + 1'b1;
          if (rsp_class && (pos_count != {CNT_W{1'b1}}))
            pos_count <= pos_count + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
